// File: rtl/spi_pkg.sv
// Shared types for the SPI mode-0 responder: frame width, FSM states, edge flags.
// Types only; no logic, no latency, no flow control.
package spi_pkg;

    localparam int SPI_FRAME_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_e;

    typedef struct packed {
        logic cs_fall;
        logic cs_rise;
        logic sck_rise;
        logic sck_fall;
    } edge_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Host-side word interface of the SPI responder: TX holding-register write, RX word out.
// tx_valid/tx_ready handshake; rx_valid is a 1-cycle pulse and cannot be stalled.
interface spi_slave_rx_if #(
    parameter int DATA_W = spi_pkg::SPI_FRAME_W
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_pin_sync.sv
// N-stage synchroniser for one async pin plus rise/fall detect on the synced level.
// Latency STAGES clk to level, edge flags in the same cycle; no backpressure.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder (MSB first, fixed DATA_W frames) with one TX holding register.
// rx_valid <= SYNC_STAGES+2 clk after last sclk rise; tx_ready low while buffer full. SPI_SLV_ERR_EN adds error pulses.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_FRAME_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic cs_n_i,
    spi_slave_rx_if.slave host,
    output logic miso_o
`ifdef SPI_SLV_ERR_EN
    ,
    output logic udr_err_o,
    output logic abt_err_o,
    output logic ovr_err_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    edge_t ev;
    logic  mosi_lvl;
    logic  sck_unused_lvl, cs_unused_lvl, mosi_unused_rise, mosi_unused_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin_i(sclk_i),
        .lvl_o(sck_unused_lvl), .rise_o(ev.sck_rise), .fall_o(ev.sck_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin_i(cs_n_i),
        .lvl_o(cs_unused_lvl), .rise_o(ev.cs_rise), .fall_o(ev.cs_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin_i(mosi_i),
        .lvl_o(mosi_lvl), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall)
    );

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               miso_q, miso_d;
    logic [DATA_W-1:0]  txbuf_q, txbuf_d;
    logic               txfull_q, txfull_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            txbuf_q    <= '0;
            txfull_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            txbuf_q    <= txbuf_d;
            txfull_q   <= txfull_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        txbuf_d    = txbuf_q;
        txfull_d   = txfull_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ev.cs_fall) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    if (txfull_q) begin
                        shift_d  = txbuf_q;
                        txfull_d = 1'b0;
                    end else begin
                        shift_d = '0;
                    end
                    miso_d = shift_d[DATA_W-1];
                end
            end
            ACTIVE: begin
                // Deselect wins over a coincident sclk edge: the frame is simply dropped.
                if (ev.cs_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else if (ev.sck_rise) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_lvl};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = DONE;
                        miso_d     = 1'b0;
                    end
                end else if (ev.sck_fall) begin
                    miso_d = shift_q[DATA_W-1];
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (ev.cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase

        // A write coinciding with a frame start lands after the load, so it is kept for the next frame.
        if (host.tx_valid && !txfull_q) begin
            txbuf_d  = host.tx_data;
            txfull_d = 1'b1;
        end
    end

    assign miso_o        = miso_q;
    assign host.tx_ready = ~txfull_q;
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;
    assign host.busy     = (state_q != IDLE);

`ifdef SPI_SLV_ERR_EN
    localparam int GAP_LIM = SYNC_STAGES + 2;

    logic       udr_q, abt_q, ovr_q, seen_q;
    logic [7:0] gap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            udr_q  <= 1'b0;
            abt_q  <= 1'b0;
            ovr_q  <= 1'b0;
            seen_q <= 1'b0;
            gap_q  <= '0;
        end else begin
            udr_q <= (state_q == IDLE) && ev.cs_fall && !txfull_q;
            abt_q <= (state_q == ACTIVE) && ev.cs_rise;
            ovr_q <= 1'b0;
            if (rx_valid_d) begin
                ovr_q  <= seen_q && (gap_q < 8'(GAP_LIM));
                seen_q <= 1'b1;
                gap_q  <= '0;
            end else if (gap_q != 8'hFF) begin
                gap_q <= gap_q + 8'd1;
            end
        end
    end

    assign udr_err_o = udr_q;
    assign abt_err_o = abt_q;
    assign ovr_err_o = ovr_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: bit-banged mode-0 master at clk/52 with a scoreboard on received words.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int HALF = 26;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs_n = 1'b1;
    logic miso;

    spi_slave_rx_if #(.DATA_W(32)) host ();

`ifdef SPI_SLV_ERR_EN
    logic udr_err, abt_err, ovr_err;
    int   udr_cnt = 0, abt_cnt = 0, ovr_cnt = 0;
`endif

    spi_slave_rx #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .sclk_i (sclk),
        .mosi_i (mosi),
        .cs_n_i (cs_n),
        .host   (host),
        .miso_o (miso)
`ifdef SPI_SLV_ERR_EN
        ,
        .udr_err_o (udr_err),
        .abt_err_o (abt_err),
        .ovr_err_o (ovr_err)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          rxv_cnt = 0;
    logic        rxv_prev = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse is matched against the next queued word.
    always @(negedge clk) begin
        if (host.rx_valid === 1'b1) begin
            rxv_cnt++;
            check("rx_valid_1cycle", {31'd0, rxv_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rx_unexpected: got %h, expected no word", host.rx_data);
            end else begin
                check("rx_word", host.rx_data, exp_q.pop_front());
            end
        end
        rxv_prev = host.rx_valid;
`ifdef SPI_SLV_ERR_EN
        if (udr_err === 1'b1) udr_cnt++;
        if (abt_err === 1'b1) abt_cnt++;
        if (ovr_err === 1'b1) ovr_cnt++;
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_tx(input logic [31:0] d);
        host.tx_data  = d;
        host.tx_valid = 1'b1;
        wait_clk(1);
        host.tx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     {31'd0, miso},          32'd0);
        check({tag, "_tx_ready"}, {31'd0, host.tx_ready}, 32'd1);
        check({tag, "_rx_valid"}, {31'd0, host.rx_valid}, 32'd0);
        check({tag, "_busy"},     {31'd0, host.busy},     32'd0);
        check({tag, "_rx_data"},  host.rx_data,           32'd0);
    endtask

    // Mode-0 master: data set while sclk low, both sides sample on the rising edge.
    task automatic spi_xfer(input logic [31:0] wr, input int nbits, input bit rst_at16,
                            output logic [31:0] rd);
        bit aborted;
        aborted = 1'b0;
        rd      = '0;
        cs_n    = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!aborted) begin
                if (rst_at16 && i == 16) begin
                    @(negedge clk);
                    check("busy_mid_frame", {31'd0, host.busy}, 32'd1);
                    rst = 1'b1;
                    @(negedge clk);
                    check_reset_outputs("midrst");
                    cs_n = 1'b1;
                    sclk = 1'b0;
                    wait_clk(4);
                    rst = 1'b0;
                    aborted = 1'b1;
                end else begin
                    mosi = wr[31-i];
                    wait_clk(HALF);
                    sclk = 1'b1;
                    rd[31-i] = miso;
                    wait_clk(HALF);
                    sclk = 1'b0;
                end
            end
        end
        if (!aborted) begin
            wait_clk(HALF);
            cs_n = 1'b1;
        end
    endtask

    logic [31:0] rd, rd2;

    initial begin
        host.tx_data  = '0;
        host.tx_valid = 1'b0;

        // 1: reset values
        wait_clk(3);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(4);

        // 2: loaded TX word goes out while DEADBEEF comes in
        load_tx(32'hA5A51234);
        @(negedge clk);
        check("t2_tx_ready_full", {31'd0, host.tx_ready}, 32'd0);
        exp_q.push_back(32'hDEADBEEF);
        spi_xfer(32'hDEADBEEF, 32, 1'b0, rd);
        wait_clk(10);
        check("t2_miso_word", rd, 32'hA5A51234);
        check("t2_rx_data", host.rx_data, 32'hDEADBEEF);
        check("t2_rx_pulses", rxv_cnt, 32'd1);
        check("t2_tx_ready_freed", {31'd0, host.tx_ready}, 32'd1);
        check("t2_busy_idle", {31'd0, host.busy}, 32'd0);

        // 3: empty TX buffer sends zeros
        exp_q.push_back(32'h00000001);
        spi_xfer(32'h00000001, 32, 1'b0, rd);
        wait_clk(10);
        check("t3_miso_word", rd, 32'h00000000);
        check("t3_rx_data", host.rx_data, 32'h00000001);
        check("t3_rx_pulses", rxv_cnt, 32'd2);
`ifdef SPI_SLV_ERR_EN
        check("t3_udr_pulses", udr_cnt, 32'd1);
`endif

        // 4: deselect after 10 bits drops the frame, next frame is clean
        spi_xfer(32'hFFFFFFFF, 10, 1'b0, rd);
        wait_clk(10);
        check("t4_abort_no_rx", rxv_cnt, 32'd2);
        check("t4_abort_rx_held", host.rx_data, 32'h00000001);
`ifdef SPI_SLV_ERR_EN
        check("t4_abt_pulses", abt_cnt, 32'd1);
`endif
        exp_q.push_back(32'h12345678);
        spi_xfer(32'h12345678, 32, 1'b0, rd);
        wait_clk(10);
        check("t4_rx_data", host.rx_data, 32'h12345678);
        check("t4_rx_pulses", rxv_cnt, 32'd3);

        // 5: back-to-back frames, 4 clk deselect gap with TX reload inside it
        load_tx(32'h0F0F0F0F);
        exp_q.push_back(32'h11111111);
        spi_xfer(32'h11111111, 32, 1'b0, rd);
        load_tx(32'h5555AAAA);
        wait_clk(3);
        exp_q.push_back(32'h89ABCDEF);
        spi_xfer(32'h89ABCDEF, 32, 1'b0, rd2);
        wait_clk(10);
        check("t5_miso_word1", rd, 32'h0F0F0F0F);
        check("t5_miso_word2", rd2, 32'h5555AAAA);
        check("t5_rx_data", host.rx_data, 32'h89ABCDEF);
        check("t5_rx_pulses", rxv_cnt, 32'd5);

        // 6: reset at bit 16, then a clean frame
        spi_xfer(32'h87654321, 32, 1'b1, rd);
        wait_clk(4);
        check("t6_no_rx_after_rst", rxv_cnt, 32'd5);
        load_tx(32'h600DF00D);
        exp_q.push_back(32'hCAFEF00D);
        spi_xfer(32'hCAFEF00D, 32, 1'b0, rd);
        wait_clk(10);
        check("t6_miso_word", rd, 32'h600DF00D);
        check("t6_rx_data", host.rx_data, 32'hCAFEF00D);
        check("t6_rx_pulses", rxv_cnt, 32'd6);

        check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef SPI_SLV_ERR_EN
        check("ovr_pulses", ovr_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
